// File: rtl/divider_16x8_seq.sv
// ============================================================================
// Module   : divider_16x8_seq
// Purpose  : Sequential unsigned radix-2 restoring divider, one quotient bit
//            per clock, with valid/ready handshakes on input and output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module divider_16x8_seq #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          q_ovf,
  output logic          div_zero
);

  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  // Dividend bits shift out of the MSB while quotient bits shift into the LSB.
  logic [DW-1:0] r_work;
  logic [VW-1:0] r_dvs;
  logic [VW-1:0] r_p;
  logic [CW-1:0] r_cnt;

  logic [VW:0]   w_shift;
  logic          w_ge;
  logic [VW-1:0] w_p_next;
  logic [DW-1:0] w_q_next;

  always_comb begin
    w_shift  = {r_p, r_work[DW-1]};
    w_ge     = (w_shift >= {1'b0, r_dvs});
    // Modulo-2^VW subtraction is exact because the true difference is < divisor.
    w_p_next = w_ge ? (w_shift[VW-1:0] - r_dvs) : w_shift[VW-1:0];
    w_q_next = {r_work[DW-2:0], w_ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_work    <= '0;
      r_dvs     <= '0;
      r_p       <= '0;
      r_cnt     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      q_ovf     <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_work   <= dividend;
            r_dvs    <= divisor;
            r_p      <= '0;
            in_ready <= 1'b0;
            if (divisor == '0) begin
              r_state   <= S_DONE;
              quotient  <= '1;
              remainder <= '0;
              q_ovf     <= 1'b1;
              div_zero  <= 1'b1;
            end else begin
              r_state <= S_CALC;
              r_cnt   <= CW'(DW - 1);
            end
          end
        end
        S_CALC: begin
          r_p    <= w_p_next;
          r_work <= w_q_next;
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_state   <= S_DONE;
            out_valid <= 1'b1;
            quotient  <= w_q_next;
            remainder <= w_p_next;
            q_ovf     <= |w_q_next[DW-1:VW];
            div_zero  <= 1'b0;
          end
        end
        S_DONE: begin
          // Divide-by-zero enters here with out_valid low; raise it one cycle later.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_divider_16x8_seq.sv
// ============================================================================
// Module   : tb_divider_16x8_seq
// Purpose  : Scoreboard bench for divider_16x8_seq with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_divider_16x8_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        q_ovf;
  logic        div_zero;

  typedef struct packed {
    logic [15:0] q;
    logic [7:0]  r;
    logic        ovf;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  divider_16x8_seq #(.DW(16), .VW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .q_ovf     (q_ovf),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", {16'd0, quotient}, {16'd0, e.q});
        chk("remainder", {24'd0, remainder}, {24'd0, e.r});
        chk("q_ovf", {31'd0, q_ovf}, {31'd0, e.ovf});
        chk("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [7:0] b, input exp_t e);
    int n;
    n = 0;
    while (!in_ready && n < 60) begin
      cyc();
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    sb.push_back(e);
    cyc();
    in_valid = 1'b0;
  endtask

  // Counts edges after the accepting edge until out_valid is seen.
  task automatic check_latency(input string name, input int exp_lat);
    int lat;
    lat = 0;
    while (!out_valid && lat < 40) begin
      cyc();
      lat++;
    end
    chk(name, lat, exp_lat);
  endtask

  task automatic drain(input bit rnd_stall);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      if (rnd_stall) out_ready = ($urandom_range(0, 3) != 0);
      cyc();
      n++;
    end
    out_ready = 1'b1;
    chk("drain_timeout", sb.size(), 0);
    cyc();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    cyc();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_quotient", {16'd0, quotient}, 32'd0);
    chk("rst_flags", {30'd0, q_ovf, div_zero}, 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    send(16'd200, 8'd7, '{q: 16'd28, r: 8'd4, ovf: 1'b0, dz: 1'b0});
    check_latency("latency_basic", 16);
    drain(1'b0);

    send(16'd65535, 8'd255, '{q: 16'd257, r: 8'd0, ovf: 1'b1, dz: 1'b0});
    drain(1'b0);
    send(16'd65535, 8'd1, '{q: 16'd65535, r: 8'd0, ovf: 1'b1, dz: 1'b0});
    drain(1'b0);

    send(16'h1234, 8'd0, '{q: 16'hFFFF, r: 8'd0, ovf: 1'b1, dz: 1'b1});
    check_latency("latency_divzero", 1);
    drain(1'b0);

    // Backpressure with input noise during the computation.
    out_ready = 1'b0;
    send(16'd1000, 8'd10, '{q: 16'd100, r: 8'd0, ovf: 1'b0, dz: 1'b0});
    for (int i = 0; i < 40 && !out_valid; i++) begin
      in_valid = i[0];
      dividend = 16'($urandom);
      divisor  = 8'($urandom);
      chk("calc_in_ready", {31'd0, in_ready}, 32'd0);
      cyc();
    end
    in_valid = 1'b0;
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_quot", {16'd0, quotient}, 32'd100);
      chk("bp_hold_rem", {24'd0, remainder}, 32'd0);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    cyc();
    chk("bp_idle_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_idle_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_sb_empty", sb.size(), 0);

    // Reset during the seventh computation cycle discards the operation.
    send(16'd200, 8'd7, '{q: 16'd28, r: 8'd4, ovf: 1'b0, dz: 1'b0});
    repeat (6) cyc();
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_outputs", {quotient, remainder, 6'd0, q_ovf, div_zero}, 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    send(16'd50, 8'd3, '{q: 16'd16, r: 8'd2, ovf: 1'b0, dz: 1'b0});
    check_latency("latency_after_rst", 16);
    drain(1'b0);

    // Round trip of products back through the divider.
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] a;
      logic [7:0] b;
      a = 8'($urandom);
      b = 8'($urandom_range(1, 255));
      send(16'(a) * 16'(b), b, '{q: {8'd0, a}, r: 8'd0, ovf: 1'b0, dz: 1'b0});
      drain(1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
